playback_control: RTL and testbench
===================================

Name: playback_control

Overview:
Upstream control stage for the Timer block: turns raw player buttons into the Timer's count/reset/adder controls.
- Debounces the play/pause, stop and fast-forward buttons.
- Runs the playback state machine and divides the system clock into a one-second tick.
- Drives Timer.count with a single-cycle advance pulse, Timer.reset with a clear pulse, and Timer.adder with the step size.

Parameters:
TICK_DIV, 50_000_000, clk cycles per playback second; count pulses once every TICK_DIV cycles while running
DEBOUNCE_CYCLES, 500_000, consecutive stable synchronized cycles required before a button level is accepted
FF_STEP, 8, adder value driven in fast-forward (6-bit, 1..63)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
btn_play  input  1  raw play/pause button, active-high, asynchronous to clk
btn_stop  input  1  raw stop button, active-high
btn_ff  input  1  raw fast-forward toggle button, active-high
song_end  input  1  synchronous level from sequencer: current song finished
count  output  1  one-cycle advance pulse to Timer
timer_reset  output  1  one-cycle clear pulse to Timer (active-high, as the Timer expects)
adder  output  6  step added by Timer on each count pulse
state  output  2  00 STOPPED, 01 PLAYING, 10 PAUSED, 11 FFWD
playing  output  1  high in PLAYING or FFWD (enables the audio path)

Behaviour:
- Reset (reset=0, async):
  - state=STOPPED; count=0, timer_reset=0, adder=1, playing=0.
  - Prescaler and debounce counters are 0; synchronizers are 0.
- Button path, per button:
  - 2-FF synchronizer, then debounce counter; accepted level changes only after DEBOUNCE_CYCLES equal consecutive samples.
  - Rising edge of the accepted level gives a one-cycle press event.
  - Clean press: event occurs DEBOUNCE_CYCLES+3 cycles after the raw rise. Bounces shorter than DEBOUNCE_CYCLES produce no event.
- Event priority when coincident in one cycle: stop > song_end > play > ff. Lower-priority events in that cycle are discarded, not queued.
- FSM transitions:
  - STOPPED: play -> PLAYING. ff, song_end ignored.
  - PLAYING: play -> PAUSED; ff -> FFWD; stop -> STOPPED; song_end -> STOPPED.
  - PAUSED: play -> PLAYING; stop -> STOPPED; ff ignored; song_end -> STOPPED.
  - FFWD: ff -> PLAYING; play -> PAUSED; stop -> STOPPED; song_end -> STOPPED.
- Entering STOPPED from any other state:
  - timer_reset pulses high for exactly one cycle, on the cycle after the transition.
  - Prescaler cleared to 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 in PLAYING/FFWD and wraps to 0.
  - Frozen in PAUSED, so partial seconds are preserved across pause.
  - Held at 0 in STOPPED.
- count:
  - Registered; high for one cycle on the cycle after the prescaler reaches TICK_DIV-1 while running.
  - Never high in STOPPED or PAUSED, including the tick cycle on which a pause or stop takes effect.
  - Never high in the same cycle as timer_reset.
- adder:
  - 1 in STOPPED/PLAYING/PAUSED, FF_STEP in FFWD.
  - Registered; updates on the same edge as state, so it is stable one full cycle before any count pulse using it.
- playing = registered decode of state.
- Async reset mid-operation aborts any pending pulse; no pulse is emitted after reset deasserts until a new event occurs.
- TICK_DIV=1: count high every cycle while running.

Optional Feature:
PLAYBACK_AUTOREPEAT_EN
- Defined:
  - song_end in PLAYING or FFWD pulses timer_reset for one cycle, clears the prescaler, and enters PLAYING (FFWD drops to normal speed). Playback restarts from 0:00.
  - song_end in PAUSED still goes to STOPPED.
- Undefined: song_end behaves as listed in Behaviour (-> STOPPED).

Test Plan:
All scenarios use TICK_DIV=10, DEBOUNCE_CYCLES=4, FF_STEP=8.
1. Release reset, press btn_play clean for 20 cycles -> state 01 seven cycles after rise; count pulses every 10 cycles, adder=1, timer_reset never high.
2. From PLAYING at prescaler=6, press btn_play; hold 50 cycles; press btn_play again -> no count while PAUSED; first count after resume comes 3 cycles after prescaler restarts from 7 (frozen value 6 kept).
3. In PLAYING, press btn_ff -> state 11, adder=8 before next count; press btn_ff again -> state 01, adder=1.
4. Toggle btn_stop 1-0-1-0 at 2-cycle intervals then hold high -> a single stop event only; one timer_reset pulse; state 00; prescaler 0.
5. btn_stop and btn_play events in the same cycle while PLAYING -> STOPPED wins; no PAUSED visit.
6. song_end high in FFWD -> without macro: STOPPED plus one timer_reset pulse. With PLAYBACK_AUTOREPEAT_EN: timer_reset pulse, state 01, adder=1, first count 10 cycles later.

Source files
------------

// File: rtl/playback_control.sv
// Player button front end: debounces play/stop/ff, runs the playback FSM and drives Timer count/reset/adder.
// Optional PLAYBACK_AUTOREPEAT_EN: song_end while running restarts playback from 0:00 instead of stopping.

module playback_control_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

  // cnt_q counts consecutive synchronized samples that disagree with the accepted level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      press_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        press_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;
endmodule

module playback_control #(
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int FF_STEP         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_play,
  input  logic       btn_stop,
  input  logic       btn_ff,
  input  logic       song_end,
  output logic       count,
  output logic       timer_reset,
  output logic [5:0] adder,
  output logic [1:0] state,
  output logic       playing
);
  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_PLAYING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_FFWD    = 2'b11
  } state_e;

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam int            NBTN     = 3;
  localparam int            B_PLAY   = 0;
  localparam int            B_STOP   = 1;
  localparam int            B_FF     = 2;
`ifdef PLAYBACK_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic [NBTN-1:0] btn, press;
  assign btn = {btn_ff, btn_stop, btn_play};

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    playback_control_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .btn_i(btn[g]), .press_o(press[g])
    );
  end

  // Only the highest-priority event of a cycle survives; the rest are dropped
  logic ev_stop, ev_end, ev_play, ev_ff;
  always_comb begin
    ev_stop = press[B_STOP];
    ev_end  = song_end & ~ev_stop;
    ev_play = press[B_PLAY] & ~ev_stop & ~song_end;
    ev_ff   = press[B_FF] & ~ev_stop & ~song_end & ~press[B_PLAY];
  end

  state_e        state_q, state_d;
  logic          restart;
  logic [PW-1:0] pre_q, pre_d;
  logic          count_q, count_d, tr_q, tr_d, playing_q, playing_d;
  logic [5:0]    adder_q, adder_d;
  logic          run_now, run_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_STOPPED;
      pre_q     <= '0;
      count_q   <= 1'b0;
      tr_q      <= 1'b0;
      adder_q   <= 6'd1;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      count_q   <= count_d;
      tr_q      <= tr_d;
      adder_q   <= adder_d;
      playing_q <= playing_d;
    end
  end

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      ST_STOPPED: if (ev_play) state_d = ST_PLAYING;
      ST_PLAYING, ST_FFWD: begin
        if (ev_stop) state_d = ST_STOPPED;
        else if (ev_end) begin
          if (AUTOREPEAT) begin
            restart = 1'b1;
            state_d = ST_PLAYING;
          end else begin
            state_d = ST_STOPPED;
          end
        end
        else if (ev_play) state_d = ST_PAUSED;
        else if (ev_ff) state_d = (state_q == ST_FFWD) ? ST_PLAYING : ST_FFWD;
      end
      ST_PAUSED: begin
        if (ev_stop || ev_end) state_d = ST_STOPPED;
        else if (ev_play) state_d = ST_PLAYING;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Prescaler advances only while running on both sides of the edge, so a pause freezes it untouched
  always_comb begin
    run_now   = (state_q == ST_PLAYING) || (state_q == ST_FFWD);
    run_next  = (state_d == ST_PLAYING) || (state_d == ST_FFWD);
    tr_d      = restart | ((state_d == ST_STOPPED) && (state_q != ST_STOPPED));
    count_d   = run_now & run_next & ~restart & (pre_q == PRE_LAST);
    if ((state_d == ST_STOPPED) || restart) pre_d = '0;
    else if (run_now && run_next)           pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    else                                    pre_d = pre_q;
    adder_d   = (state_d == ST_FFWD) ? 6'(FF_STEP) : 6'd1;
    playing_d = run_next;
  end

  assign count       = count_q;
  assign timer_reset = tr_q;
  assign adder       = adder_q;
  assign state       = state_q;
  assign playing     = playing_q;
endmodule

// File: tb/tb_playback_control.sv
// Directed bench for playback_control: scoreboard of expected state transitions plus cycle-exact pulse checks.
module tb_playback_control;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_play = 1'b0, btn_stop = 1'b0, btn_ff = 1'b0, song_end = 1'b0;
  logic       count, timer_reset, playing;
  logic [5:0] adder;
  logic [1:0] state;

  localparam logic [1:0] S_STOP = 2'b00, S_PLAY = 2'b01, S_PAUSE = 2'b10, S_FF = 2'b11;

  playback_control #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4), .FF_STEP(8)) dut (
    .clk(clk), .reset(reset), .btn_play(btn_play), .btn_stop(btn_stop), .btn_ff(btn_ff),
    .song_end(song_end), .count(count), .timer_reset(timer_reset), .adder(adder),
    .state(state), .playing(playing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic [5:0] add;
    logic       ply;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0, n_fail = 0;
  int   n_tr = 0, n_cnt = 0, n_viol = 0;
  bit   mon_en = 1'b0;
  logic [1:0] prev_state = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] st, input logic [5:0] add, input logic ply);
    exp_t e;
    e.st = st; e.add = add; e.ply = ply;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every observed state change must match the next expected transition
  always @(negedge clk) begin
    if (mon_en) begin
      if (timer_reset) n_tr++;
      if (count) n_cnt++;
      if (reset && count && (state == S_STOP || state == S_PAUSE)) n_viol++;
      if (count && timer_reset) n_viol++;
      if (state !== prev_state) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_state_change", 32'(state), 32'(prev_state));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_state", 32'(state), 32'(e.st));
          chk("sb_adder", 32'(adder), 32'(e.add));
          chk("sb_playing", 32'(playing), 32'(e.ply));
        end
      end
    end
    prev_state = state;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] exp, input int exp_lat);
    int lat = 0;
    while (state !== exp && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, 32'(lat), 32'(exp_lat));
  endtask

  // Expect the first count pulse exactly n samples from now, carrying the given adder
  task automatic cnt_wait(input string tag, input int n, input logic [5:0] add);
    int first = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (count && first == 0) first = i;
    end
    chk(tag, 32'(first), 32'(n));
    chk({tag, "_adder"}, 32'(adder), 32'(add));
  endtask

  initial begin
    int quiet, snap;
    #1 reset = 1'b0;
    tick(2);
    chk("rst_state", 32'(state), 32'(S_STOP));
    chk("rst_count", 32'(count), 0);
    chk("rst_treset", 32'(timer_reset), 0);
    chk("rst_adder", 32'(adder), 1);
    chk("rst_playing", 32'(playing), 0);
    reset = 1'b1;
    mon_en = 1'b1;
    tick(2);

    // clean play press -> PLAYING 7 cycles after rise, counts every 10 cycles
    push(S_PLAY, 6'd1, 1'b1);
    btn_play = 1'b1;
    wait_state("play_latency", S_PLAY, 7);
    cnt_wait("first_count", 10, 6'd1);
    btn_play = 1'b0;
    cnt_wait("second_count", 10, 6'd1);
    chk("no_treset_playing", 32'(n_tr), 0);

    // pause with prescaler at 6, hold 50 cycles, resume
    push(S_PAUSE, 6'd1, 1'b0);
    btn_play = 1'b1;
    wait_state("pause_latency", S_PAUSE, 7);
    btn_play = 1'b0;
    quiet = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (count) quiet++;
    end
    chk("paused_no_count", 32'(quiet), 0);
    push(S_PLAY, 6'd1, 1'b1);
    btn_play = 1'b1;
    wait_state("resume_latency", S_PLAY, 7);
    cnt_wait("resume_count", 4, 6'd1);
    btn_play = 1'b0;

    // fast-forward toggle
    push(S_FF, 6'd8, 1'b1);
    btn_ff = 1'b1;
    wait_state("ffwd_latency", S_FF, 7);
    cnt_wait("ffwd_count", 3, 6'd8);
    btn_ff = 1'b0;
    tick(8);
    push(S_PLAY, 6'd1, 1'b1);
    btn_ff = 1'b1;
    wait_state("ff_off_latency", S_PLAY, 7);
    cnt_wait("ff_off_count", 5, 6'd1);
    btn_ff = 1'b0;
    tick(8);

    // bouncing stop yields exactly one stop event
    push(S_STOP, 6'd1, 1'b0);
    btn_stop = 1'b1; tick(2); btn_stop = 1'b0; tick(2);
    btn_stop = 1'b1; tick(2); btn_stop = 1'b0; tick(2);
    btn_stop = 1'b1;
    wait_state("stop_latency", S_STOP, 7);
    chk("stop_treset_hi", 32'(timer_reset), 1);
    tick(1);
    chk("stop_treset_lo", 32'(timer_reset), 0);
    btn_stop = 1'b0;
    tick(8);
    chk("stop_treset_total", 32'(n_tr), 1);

    // song_end and ff are ignored in STOPPED
    song_end = 1'b1; tick(1); song_end = 1'b0;
    btn_ff = 1'b1; tick(10); btn_ff = 1'b0; tick(8);
    chk("stopped_ignores", 32'(state), 32'(S_STOP));

    // restart from STOPPED: prescaler was cleared
    push(S_PLAY, 6'd1, 1'b1);
    btn_play = 1'b1;
    wait_state("replay_latency", S_PLAY, 7);
    cnt_wait("replay_count", 10, 6'd1);
    btn_play = 1'b0;
    tick(8);

    // coincident stop and play: stop wins, no PAUSED visit
    push(S_STOP, 6'd1, 1'b0);
    btn_stop = 1'b1; btn_play = 1'b1;
    wait_state("coincide_latency", S_STOP, 7);
    chk("coincide_treset", 32'(timer_reset), 1);
    btn_stop = 1'b0; btn_play = 1'b0;
    tick(8);
    chk("coincide_treset_total", 32'(n_tr), 2);

    // song_end in FFWD
    push(S_PLAY, 6'd1, 1'b1);
    btn_play = 1'b1;
    wait_state("pre_ff_play", S_PLAY, 7);
    btn_play = 1'b0;
    tick(8);
    push(S_FF, 6'd8, 1'b1);
    btn_ff = 1'b1;
    wait_state("pre_end_ff", S_FF, 7);
    btn_ff = 1'b0;
    tick(8);
`ifdef PLAYBACK_AUTOREPEAT_EN
    push(S_PLAY, 6'd1, 1'b1);
    song_end = 1'b1; tick(1); song_end = 1'b0;
    chk("end_state", 32'(state), 32'(S_PLAY));
    chk("end_treset", 32'(timer_reset), 1);
    cnt_wait("repeat_count", 10, 6'd1);
`else
    push(S_STOP, 6'd1, 1'b0);
    song_end = 1'b1; tick(1); song_end = 1'b0;
    chk("end_state", 32'(state), 32'(S_STOP));
    chk("end_treset", 32'(timer_reset), 1);
    tick(1);
    push(S_PLAY, 6'd1, 1'b1);
    btn_play = 1'b1;
    wait_state("pre_reset_play", S_PLAY, 7);
    btn_play = 1'b0;
`endif
    chk("end_treset_total", 32'(n_tr), 3);
    tick(5);

    // async reset mid-playback aborts everything
    push(S_STOP, 6'd1, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'(S_STOP));
    chk("async_count", 32'(count), 0);
    chk("async_adder", 32'(adder), 1);
    chk("async_playing", 32'(playing), 0);
    tick(2);
    reset = 1'b1;
    snap = n_cnt;
    tick(25);
    chk("post_reset_no_count", 32'(n_cnt), 32'(snap));
    chk("post_reset_no_treset", 32'(n_tr), 3);
    chk("invariant_violations", 32'(n_viol), 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
